// File: rtl/pwm_gen.sv
// Per-transducer PWM generator: converts (duty, phase) into rise/fall thresholds per channel
// and commits them only at a period boundary so every pulse is emitted whole.
module pwm_gen #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE,
    input  logic [WIDTH-1:0] CYCLE    [0:DEPTH-1],
    input  logic [WIDTH-1:0] TIME_CNT [0:DEPTH-1],
    input  logic [WIDTH-1:0] DUTY     [0:DEPTH-1],
    input  logic [WIDTH-1:0] PHASE    [0:DEPTH-1],
    output logic             PWM_OUT  [0:DEPTH-1]
);

    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_NORMAL} mode_t;
    typedef enum logic {IDLE, PENDING} state_t;

    logic [WIDTH-1:0] duty_r   [0:DEPTH-1];
    logic [WIDTH-1:0] phase_r  [0:DEPTH-1];
    logic [WIDTH-1:0] cycle_r  [0:DEPTH-1];
    logic [WIDTH-1:0] phase_cl [0:DEPTH-1];
    logic [WIDTH:0]   rise_raw [0:DEPTH-1];
    logic [WIDTH:0]   fall_raw [0:DEPTH-1];
    logic [WIDTH-1:0] rise_c   [0:DEPTH-1];
    logic [WIDTH-1:0] fall_c   [0:DEPTH-1];
    mode_t            mode_c   [0:DEPTH-1];

    logic [WIDTH-1:0] rise_s [0:DEPTH-1];
    logic [WIDTH-1:0] fall_s [0:DEPTH-1];
    mode_t            mode_s [0:DEPTH-1];
    logic [WIDTH-1:0] rise_p [0:DEPTH-1];
    logic [WIDTH-1:0] fall_p [0:DEPTH-1];
    mode_t            mode_p [0:DEPTH-1];
    logic [WIDTH-1:0] rise_a [0:DEPTH-1];
    logic [WIDTH-1:0] fall_a [0:DEPTH-1];
    mode_t            mode_a [0:DEPTH-1];

    logic [WIDTH-1:0] rise_e [0:DEPTH-1];
    logic [WIDTH-1:0] fall_e [0:DEPTH-1];
    mode_t            mode_e [0:DEPTH-1];
    logic             pwm_c  [0:DEPTH-1];

    state_t state      [0:DEPTH-1];
    state_t state_next [0:DEPTH-1];
    logic   capture    [0:DEPTH-1];
    logic   commit_sh  [0:DEPTH-1];
    logic   commit_pd  [0:DEPTH-1];

    logic upd_q;
    logic upd_p;

    assign upd_p = UPDATE & ~upd_q;

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            duty_r[i]  <= DUTY[i];
            phase_r[i] <= PHASE[i];
            cycle_r[i] <= CYCLE[i];
        end
    end

    // Thresholds use one extra bit so the wrap tests see the true sign / overflow.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            phase_cl[i] = (phase_r[i] >= cycle_r[i]) ? cycle_r[i] - WIDTH'(1) : phase_r[i];
            rise_raw[i] = {1'b0, phase_cl[i]} - {1'b0, duty_r[i] >> 1};
            fall_raw[i] = {1'b0, phase_cl[i]} + (({1'b0, duty_r[i]} + (WIDTH+1)'(1)) >> 1);
            rise_c[i]   = rise_raw[i][WIDTH] ? rise_raw[i][WIDTH-1:0] + cycle_r[i]
                                             : rise_raw[i][WIDTH-1:0];
            fall_c[i]   = (fall_raw[i] >= {1'b0, cycle_r[i]})
                          ? WIDTH'(fall_raw[i] - {1'b0, cycle_r[i]})
                          : fall_raw[i][WIDTH-1:0];
            if (duty_r[i] >= cycle_r[i])
                mode_c[i] = MODE_ON;
            else if (duty_r[i] == '0)
                mode_c[i] = MODE_OFF;
            else
                mode_c[i] = MODE_NORMAL;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RST)
                state[i] <= IDLE;
            else
                state[i] <= state_next[i];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_next[i] = state[i];
            if (upd_p && TIME_CNT[i] == '0)
                state_next[i] = IDLE;
            else if (upd_p)
                state_next[i] = PENDING;
            else if (state[i] == PENDING && TIME_CNT[i] == '0)
                state_next[i] = IDLE;
        end
    end

    // The compare uses the values being committed this cycle, so count 0 of a
    // period already obeys the parameters that govern the rest of it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            capture[i]   = upd_p;
            commit_sh[i] = upd_p && TIME_CNT[i] == '0;
            commit_pd[i] = !upd_p && state[i] == PENDING && TIME_CNT[i] == '0;
            rise_e[i]    = rise_a[i];
            fall_e[i]    = fall_a[i];
            mode_e[i]    = mode_a[i];
            if (commit_sh[i]) begin
                rise_e[i] = rise_s[i];
                fall_e[i] = fall_s[i];
                mode_e[i] = mode_s[i];
            end else if (commit_pd[i]) begin
                rise_e[i] = rise_p[i];
                fall_e[i] = fall_p[i];
                mode_e[i] = mode_p[i];
            end
            case (mode_e[i])
                MODE_ON:  pwm_c[i] = 1'b1;
                MODE_OFF: pwm_c[i] = 1'b0;
                default:
                    if (rise_e[i] <= fall_e[i])
                        pwm_c[i] = (TIME_CNT[i] >= rise_e[i]) && (TIME_CNT[i] < fall_e[i]);
                    else
                        pwm_c[i] = (TIME_CNT[i] >= rise_e[i]) || (TIME_CNT[i] < fall_e[i]);
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                rise_s[i]  <= '0;
                fall_s[i]  <= '0;
                mode_s[i]  <= MODE_OFF;
                rise_p[i]  <= '0;
                fall_p[i]  <= '0;
                mode_p[i]  <= MODE_OFF;
                rise_a[i]  <= '0;
                fall_a[i]  <= '0;
                mode_a[i]  <= MODE_OFF;
                PWM_OUT[i] <= 1'b0;
            end
        end else begin
            upd_q <= UPDATE;
            for (int i = 0; i < DEPTH; i++) begin
                rise_s[i] <= rise_c[i];
                fall_s[i] <= fall_c[i];
                mode_s[i] <= mode_c[i];
                if (capture[i]) begin
                    rise_p[i] <= rise_s[i];
                    fall_p[i] <= fall_s[i];
                    mode_p[i] <= mode_s[i];
                end
                rise_a[i]  <= rise_e[i];
                fall_a[i]  <= fall_e[i];
                mode_a[i]  <= mode_e[i];
                PWM_OUT[i] <= pwm_c[i];
            end
        end
    end

endmodule
